// File: rtl/rx_frame12_pkg.sv
// Shared types and constants for the 12-bit frame receiver (rx_frame12).
package rx_frame_pkg;

  localparam int unsigned FRAME_BITS = 12;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 2;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } rx_state_t;

endpackage

// File: rtl/rx_frame12_bit_timer.sv
// Baud counter for rx_frame12: ticks at mid start bit (half select) or every full bit period.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clear,
  input  logic i_half,
  output logic o_sample_tick_c
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_target;

  // Terminal count depends on whether we are locating the middle of the start bit
  always_comb begin
    w_target        = i_half ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1);
    o_sample_tick_c = (r_cnt == w_target);
  end

  // Counter restarts on clear and after every tick so the next period starts aligned
  always_ff @(posedge CLK) begin
    if (RESET || i_clear) begin
      r_cnt <= '0;
    end else if (o_sample_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rx_frame12.sv
// Receiver for the 12-bit serial frame (start, 8 data LSB first, even parity, 2 stops).
// Optional macro RX_PARITY_EN enables the parity check; otherwise PERR stays 0.
module rx_frame12
  import rx_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RXD,
  input  logic                 ACK,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 RXRDY,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 OVR
);

  rx_state_t r_state;
  rx_state_t w_next;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic                 w_rxs;
  logic                 w_tick;
  logic                 w_tmr_clear;
  logic                 w_half;
  logic                 w_shift_en;
  logic                 w_stop_en;
  logic                 w_frame_go;
  logic                 w_frame_done;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_err;
  logic                 r_deliver;
  logic                 w_perr;

  assign w_rxs = r_sync2;

  // Two-flop synchronizer plus previous-sample register for edge detection
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
      r_prev  <= IDLE_LEVEL;
    end else begin
      r_sync1 <= RXD;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .CLK            (CLK),
    .RESET          (RESET),
    .i_clear        (w_tmr_clear),
    .i_half         (w_half),
    .o_sample_tick_c(w_tick)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; every bit after the start bit advances on a full-period tick
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_prev && !w_rxs) w_next = S_START;
      S_START:  if (w_tick) w_next = w_rxs ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && (r_bit_cnt == 3'(DATA_BITS - 1))) w_next = S_PARITY;
      S_PARITY: if (w_tick) w_next = S_STOP1;
      S_STOP1:  if (w_tick) w_next = S_STOP2;
      S_STOP2:  if (w_tick) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    w_tmr_clear  = (r_state == S_IDLE);
    w_half       = (r_state == S_START);
    w_frame_go   = (r_state == S_START) && w_tick && !w_rxs;
    w_shift_en   = (r_state == S_DATA) && w_tick;
    w_stop_en    = ((r_state == S_STOP1) || (r_state == S_STOP2)) && w_tick;
    w_frame_done = (r_state == S_STOP2) && w_tick;
  end

  // Frame datapath: bit counter, LSB-first shift register, stop error, delivery strobe
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_stop_err <= 1'b0;
      r_deliver  <= 1'b0;
    end else begin
      r_deliver <= w_frame_done;
      if (w_frame_go) begin
        r_bit_cnt  <= '0;
        r_stop_err <= 1'b0;
      end
      if (w_shift_en) begin
        r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + 3'(1);
      end
      if (w_stop_en && !w_rxs) r_stop_err <= 1'b1;
    end
  end

`ifdef RX_PARITY_EN
  logic r_par_bit;

  // Captured parity bit; even parity means data plus parity has an even count of ones
  always_ff @(posedge CLK) begin
    if (RESET)                                r_par_bit <= 1'b0;
    else if ((r_state == S_PARITY) && w_tick) r_par_bit <= w_rxs;
  end

  assign w_perr = (^r_shift) ^ r_par_bit;
`else
  assign w_perr = 1'b0;
`endif

  // Output handshake: delivery wins over ACK; delivering onto unacknowledged data flags overrun
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA  <= '0;
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVR   <= 1'b0;
    end else if (r_deliver) begin
      DATA  <= r_shift;
      PERR  <= w_perr;
      FERR  <= r_stop_err;
      OVR   <= RXRDY && !ACK;
      RXRDY <= 1'b1;
    end else if (ACK && RXRDY) begin
      RXRDY <= 1'b0;
      OVR   <= 1'b0;
    end
  end

endmodule

// File: doc/rx_frame12.md
Name: rx_frame12

Overview:
Serial receive controller and datapath for the 12-bit frame that the team's transmit controller shifts out.
- Detects the start bit and samples each bit mid-period.
- Checks parity and the two stop bits, then presents the 8-bit payload with a ready/acknowledge handshake.
- Sits at the far end of the serial link and feeds the consuming logic.

Frame, on the line LSB first:
- Bit 0: start bit, 0.
- Bits 1-8: data D0..D7.
- Bit 9: parity, even.
- Bits 10-11: two stop bits, 1.
- Line idles at 1.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per serial bit; even, >= 4.
DATA_BITS, 8, payload width; fixed by frame format; not for override.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  synchronous, active-high reset.
RXD  input  1  serial line; asynchronous to CLK.
ACK  input  1  consumer acknowledges DATA; sampled on CLK.
DATA  output  8  last received payload.
RXRDY  output  1  payload valid; held until ACK.
PERR  output  1  parity error for current DATA.
FERR  output  1  stop-bit error for current DATA.
OVR  output  1  overrun flag; sticky until ACK.

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - State IDLE; synchronizer flops and previous-sample register set to 1.
  - DATA=0, RXRDY=0, PERR=0, FERR=0, OVR=0; counters cleared.
  - Reset mid-frame abandons the frame; no flags are set.
- RXD passes through a 2-flop synchronizer, giving rxs. All logic uses rxs (+2 cycle latency).
- State machine: IDLE -> START -> DATA -> PARITY -> STOP1 -> STOP2 -> IDLE.
  - IDLE: falling edge on rxs (prev=1, now=0) -> START. Baud counter=0.
  - START: at baud count CLKS_PER_BIT/2-1, sample rxs.
    - If 1: false start -> IDLE.
    - If 0: -> DATA; baud counter=0, bit counter=0.
  - DATA: sample every CLKS_PER_BIT cycles into the shift register, LSB first. After the 8th sample -> PARITY.
  - PARITY: one sample, stored.
  - STOP1 and STOP2: one sample each. A 0 in either sets an internal frame-error bit; the frame is still delivered.
  - STOP2 sample cycle: transition to IDLE. The next start edge is accepted from the following cycle.
- Delivery, on the cycle after the STOP2 sample:
  - DATA <= shift register; PERR <= parity mismatch; FERR <= stop error; RXRDY <= 1.
  - Latency: first start-bit falling edge on RXD to RXRDY = 2 + CLKS_PER_BIT/2 + 11*CLKS_PER_BIT + 1 cycles.
- Handshake:
  - RXRDY stays 1 until a cycle with ACK=1.
  - Next cycle: RXRDY=0, OVR=0. DATA, PERR and FERR hold their values.
  - ACK while RXRDY=0: ignored.
- Overrun: a delivery while RXRDY=1 and ACK=0 overwrites DATA/PERR/FERR, sets OVR=1, and leaves RXRDY=1.
- Simultaneous ACK and delivery: delivery wins. Result is RXRDY=1, OVR=0, new DATA.
- Break (RXD held 0):
  - Produces a frame with FERR=1 and DATA=0x00.
  - No new frame starts until rxs has returned to 1 and then fallen again.
- Counters:
  - Baud counter width clog2(CLKS_PER_BIT); wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter width 3; counts 0..7 in DATA only.

Optional Feature:
RX_PARITY_EN
- Defined: bit 9 is checked for even parity over D0..D7 plus the parity bit. PERR is driven as described in Behaviour.
- Undefined: bit 9 is still sampled and timed identically but ignored. PERR is tied to 0. Frame length is unchanged.

Decomposition:
- Package rx_frame_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - Constants: FRAME_BITS=12, DATA_BITS=8, STOP_BITS=2, IDLE_LEVEL=1'b1.
- One sub-module, rx_bit_timer:
  - Baud counter with a CLKS_PER_BIT parameter.
  - Inputs: clear, half-period select.
  - Output: sample_tick.
- Top level holds the synchronizer, FSM, shift register and handshake.

Test Plan:
CLKS_PER_BIT=4 and RX_PARITY_EN defined unless stated otherwise.
- Clean frame: send 0xA5 (bits 0,1,0,1,0,0,1,0,1,0,1,1) -> RXRDY=1 after the stated latency; DATA=0xA5, PERR=0, FERR=0, OVR=0. ACK -> RXRDY=0 next cycle, DATA still 0xA5.
- Parity error: send 0x01 with parity bit 0 -> DATA=0x01, PERR=1, FERR=0. With RX_PARITY_EN undefined, the same stimulus gives PERR=0.
- False start: RXD low for 1 bit period/2-1 cycles, then high -> back to IDLE; RXRDY stays 0. A following valid 0x3C frame is received correctly.
- Overrun: send 0x11 without ACK, then 0x22 -> DATA=0x22, OVR=1, RXRDY=1. ACK -> OVR=0, RXRDY=0. Repeat with ACK coincident with the 0x22 delivery -> OVR=0, RXRDY=1.
- Frame error / break: second stop bit 0 on 0x7E -> DATA=0x7E, FERR=1. Line held 0 for 30 bit periods -> exactly one frame with DATA=0x00, FERR=1.
- Reset mid-frame: RESET=1 during DATA bit 4 -> all outputs 0 next cycle, state IDLE. The next 0xC3 frame is received correctly.
